// File: rtl/alu_pkg.sv
// Shared encodings for the nibble-serial ALU: operand modes, FSM states and
// the per-bit operand mapping shared with the existing add/sub system.
package alu_pkg;

   typedef enum logic [1:0] {
      MODE_ADD  = 2'b00,
      MODE_SUB  = 2'b01,
      MODE_PASS = 2'b10,
      MODE_DEC  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Maps one bit of operand B according to the requested mode.
   function automatic logic map_bit(input logic [1:0] mode, input logic b);
      logic r;
      case (mode)
         MODE_ADD:  r = b;
         MODE_SUB:  r = ~b;
         MODE_PASS: r = 1'b0;
         MODE_DEC:  r = 1'b1;
         default:   r = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/result bus of the nibble-serial ALU.
interface nibble_serial_alu_if #(parameter int W = 16) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [1:0]   op_mode;
   logic         op_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, op_a, op_b, op_mode, op_cin, out_ready,
      input  in_ready, out_valid, result, cout, ovf
   );

   modport slave (
      input  in_valid, op_a, op_b, op_mode, op_cin, out_ready,
      output in_ready, out_valid, result, cout, ovf
   );
endinterface

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice: generate/propagate with flat carry terms.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [4:0] c_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Lookahead carries, each expressed directly from g/p and cin.
   always_comb begin
      c_s[0] = cin;
      c_s[1] = g_s[0] | (p_s[0] & cin);
      c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
      c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & cin);
      c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
   end

   assign s    = p_s ^ c_s[3:0];
   assign cout = c_s[4];
endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/sub/inc/dec: feeds cla4_slice one nibble per step,
// carrying Cout back to Cin through carry_q_r between steps.
module nibble_serial_alu
   import alu_pkg::*;
#(
   parameter int NIBBLES = 4,
   parameter int SETTLE  = 1
) (
   input  logic               clk,
   input  logic               rst,
   nibble_serial_alu_if.slave bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_e           state_r;
   state_e           state_s;
   logic [IDX_W-1:0] idx_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_q_r;
   logic [W-1:0]     a_q_r;
   logic [W-1:0]     y_q_r;
   logic [W-1:0]     result_r;
   logic             cout_r;
   logic             ovf_r;
   logic [W-1:0]     y_map_s;
   logic             accept_s;
   logic             capture_s;
   logic             last_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic [3:0]       a_nib_s;
   logic [3:0]       b_nib_s;
   logic [3:0]       sum_nib_s;
   logic             slice_cout_s;

   // Mode-mapped copy of operand B, sampled only on acceptance.
   always_comb begin
      y_map_s = '0;
      for (int i = 0; i < W; i++) begin
         y_map_s[i] = map_bit(bus.op_mode, bus.op_b[i]);
      end
   end

   assign a_nib_s = a_q_r[{idx_r, 2'b00} +: 4];
   assign b_nib_s = y_q_r[{idx_r, 2'b00} +: 4];

   cla4_slice u_slice (
      .a    (a_nib_s),
      .b    (b_nib_s),
      .cin  (carry_q_r),
      .s    (sum_nib_s),
      .cout (slice_cout_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and handshake decode; capture only once the slice has settled.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      last_s      = 1'b0;
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            if (bus.in_valid) begin
               accept_s = 1'b1;
               state_s  = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_W'(SETTLE)) begin
               capture_s = 1'b1;
               if (idx_r == IDX_W'(NIBBLES - 1)) begin
                  last_s  = 1'b1;
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            out_valid_s = 1'b1;
            if (bus.out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand latch, nibble/settle counters, carry chain and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r     <= '0;
         cnt_r     <= '0;
         carry_q_r <= 1'b0;
         a_q_r     <= '0;
         y_q_r     <= '0;
         result_r  <= '0;
         cout_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else if (accept_s) begin
         a_q_r     <= bus.op_a;
         y_q_r     <= y_map_s;
         carry_q_r <= bus.op_cin;
         idx_r     <= '0;
         cnt_r     <= '0;
      end else if (state_r == RUN) begin
         if (capture_s) begin
            result_r[{idx_r, 2'b00} +: 4] <= sum_nib_s;
            carry_q_r <= slice_cout_s;
            cnt_r     <= '0;
            if (last_s) begin
               cout_r <= slice_cout_s;
               ovf_r  <= (a_q_r[W-1] == y_q_r[W-1]) && (sum_nib_s[3] != a_q_r[W-1]);
               idx_r  <= '0;
            end else begin
               idx_r <= idx_r + IDX_W'(1);
            end
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.result    = result_r;
   assign bus.cout      = cout_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu (NIBBLES=4, SETTLE=1, 20 ns clock).
`timescale 1ns/1ps
module tb_nibble_serial_alu;
   typedef struct {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      longint      t_acc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   exp_t   exp_q[$];
   int     checks   = 0;
   int     errors   = 0;
   int     acc_cnt  = 0;
   int     done_cnt = 0;
   logic   prev_ov  = 1'b0;

   nibble_serial_alu_if #(.W(16)) bus ();

   nibble_serial_alu #(.NIBBLES(4), .SETTLE(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-word arithmetic on the mode-mapped operand.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] m, input logic c);
      exp_t        e;
      logic [15:0] y;
      logic [16:0] sum;
      case (m)
         2'd0:    y = b;
         2'd1:    y = ~b;
         2'd2:    y = 16'h0000;
         default: y = 16'hFFFF;
      endcase
      sum    = {1'b0, a} + {1'b0, y} + {16'd0, c};
      e.res  = sum[15:0];
      e.cout = sum[16];
      e.ovf  = (a[15] == y[15]) && (sum[15] != a[15]);
      e.t_acc = 0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic c);
      int   n = 0;
      exp_t e;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
         return;
      end
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_mode  = m;
      bus.op_cin   = c;
      bus.in_valid = 1'b1;
      e = model(a, b, m, c);
      @(posedge clk);
      e.t_acc = $time;
      exp_q.push_back(e);
      acc_cnt++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a     = 16'($urandom);
      bus.op_b     = 16'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   // Monitor: latency on rising out_valid, result check on each handshake.
   always @(negedge clk) begin
      exp_t e;
      longint lat;
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (bus.out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               lat = ($time - exp_q[0].t_acc - 10) / 20;
               check("latency", 32'(lat), 32'd8);
            end
         end
         if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", {16'd0, bus.result}, {16'd0, e.res});
            check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
            check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
            done_cnt++;
         end
         prev_ov = bus.out_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      exp_t e;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = 16'h0000;
      bus.op_b      = 16'h0000;
      bus.op_mode   = 2'b00;
      bus.op_cin    = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_result", {16'd0, bus.result}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      #24 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Add with inter-nibble carry.
      do_op(16'h00FF, 16'h0001, 2'b00, 1'b0);
      wait_drain();

      // Mid-cycle reset while holding a nonzero result.
      #5 rst = 1'b1;
      #1;
      check("mid_rst_result", {16'd0, bus.result}, 32'd0);
      check("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
      check("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      #29 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Subtract, wrap, increment/decrement forms.
      do_op(16'h0005, 16'h0007, 2'b01, 1'b1);
      do_op(16'h8000, 16'h0001, 2'b01, 1'b1);
      do_op(16'hFFFF, 16'h0001, 2'b00, 1'b0);
      do_op(16'h7FFF, 16'h0001, 2'b00, 1'b0);
      do_op(16'h0000, 16'h1234, 2'b11, 1'b0);
      do_op(16'h00FF, 16'h5555, 2'b10, 1'b1);
      wait_drain();

      // Backpressure: result held, new request refused.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      do_op(16'h1234, 16'h1111, 2'b00, 1'b0);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", {31'd0, bus.out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.op_a     = 16'($urandom);
         bus.op_b     = 16'($urandom);
         bus.op_mode  = 2'($urandom);
         #1;
         check("bp_result_stable", {16'd0, bus.result}, 32'h2345);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      do_op(16'h4000, 16'h4000, 2'b00, 1'b0);
      wait_drain();

      // Reset during RUN at idx=2 aborts the op.
      do_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b1);
      #80 rst = 1'b1;
      #1;
      check("abort_result", {16'd0, bus.result}, 32'd0);
      check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      acc_cnt = acc_cnt - exp_q.size();
      exp_q.delete();
      #24 rst = 1'b0;
      @(negedge clk);
      do_op(16'h00FF, 16'h0001, 2'b00, 1'b0);
      wait_drain();

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         do_op(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
      end
      wait_drain();

      check("ops_completed", done_cnt, acc_cnt);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
